// File: rtl/tdc_stat_accum_pkg.sv
// rtl/tdc_stat_accum_pkg.sv - shared widths and FSM state encoding for the TDC statistics block
package tdc_stat_accum_pkg;

  localparam int TDC_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } tdc_state_e;

endpackage

// File: rtl/tdc_sat_cnt.sv
// rtl/tdc_sat_cnt.sv - saturating event counter with synchronous clear
module tdc_sat_cnt #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tdc_stat_accum.sv
// rtl/tdc_stat_accum.sv - per-block mean/min/max of TDC intervals with a valid/ready result register
module tdc_stat_accum
  import tdc_stat_accum_pkg::*;
#(
  parameter int DATA_WIDTH  = TDC_DATA_WIDTH,
  parameter int LOG2_N      = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int REJECT_ZERO = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_mean,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [CNT_WIDTH-1:0]  blk_cnt,
  output logic [CNT_WIDTH-1:0]  ovr_cnt,
  output logic [CNT_WIDTH-1:0]  zero_cnt
);

  localparam int SUM_W = DATA_WIDTH + LOG2_N;

  tdc_state_e            state;
  logic [SUM_W-1:0]      sum;
  logic [LOG2_N-1:0]     smp_cnt;
  logic [DATA_WIDTH-1:0] min_r;
  logic [DATA_WIDTH-1:0] max_r;

  logic                  is_zero;
  logic                  zero_rej;
  logic                  accept;
  logic                  first;
  logic                  blk_done;
  logic                  load_ok;
  logic [SUM_W-1:0]      sum_nxt;
  logic [DATA_WIDTH-1:0] min_nxt;
  logic [DATA_WIDTH-1:0] max_nxt;

  assign is_zero  = (REJECT_ZERO != 0) && (in_data == '0);
  assign zero_rej = in_valid && !clear && is_zero;
  assign accept   = in_valid && !clear && !is_zero;
  assign first    = (state == ST_IDLE);
  // smp_cnt all-ones means this accepted sample is the N-th of the block
  assign blk_done = accept && (&smp_cnt);
  assign load_ok  = !out_valid || out_ready;

  assign sum_nxt = sum + {{LOG2_N{1'b0}}, in_data};
  assign min_nxt = (first || (in_data < min_r)) ? in_data : min_r;
  assign max_nxt = (first || (in_data > max_r)) ? in_data : max_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sum       <= '0;
      smp_cnt   <= '0;
      min_r     <= '1;
      max_r     <= '0;
      out_valid <= 1'b0;
      out_mean  <= '0;
      out_min   <= '0;
      out_max   <= '0;
    end else if (clear) begin
      state     <= ST_IDLE;
      sum       <= '0;
      smp_cnt   <= '0;
      min_r     <= '1;
      max_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (blk_done) begin
        state   <= ST_IDLE;
        sum     <= '0;
        smp_cnt <= '0;
        min_r   <= '1;
        max_r   <= '0;
      end else if (accept) begin
        state   <= ST_ACCUM;
        sum     <= sum_nxt;
        smp_cnt <= smp_cnt + 1'b1;
        min_r   <= min_nxt;
        max_r   <= max_nxt;
      end

      // A finished block wins over a plain consume; otherwise the result is lost as an overrun
      if (blk_done && load_ok) begin
        out_valid <= 1'b1;
        out_mean  <= sum_nxt[SUM_W-1:LOG2_N];
        out_min   <= min_nxt;
        out_max   <= max_nxt;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  tdc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_blk_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (blk_done && load_ok),
    .cnt   (blk_cnt)
  );

  tdc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_ovr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (blk_done && !load_ok),
    .cnt   (ovr_cnt)
  );

  tdc_sat_cnt #(.CNT_WIDTH(CNT_WIDTH)) u_zero_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clear),
    .inc   (zero_rej),
    .cnt   (zero_cnt)
  );

endmodule

// File: tb/tb_tdc_stat_accum.sv
// tb/tb_tdc_stat_accum.sv - self-checking bench for tdc_stat_accum against a block-level model
module tb_tdc_stat_accum;

  localparam int DW   = 32;
  localparam int L2N  = 2;
  localparam int N    = 1 << L2N;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          out_ready;
  logic          out_valid;
  logic [DW-1:0] out_mean;
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_max;
  logic [CW-1:0] blk_cnt;
  logic [CW-1:0] ovr_cnt;
  logic [CW-1:0] zero_cnt;

  tdc_stat_accum #(
    .DATA_WIDTH  (DW),
    .LOG2_N      (L2N),
    .CNT_WIDTH   (CW),
    .REJECT_ZERO (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_mean  (out_mean),
    .out_min   (out_min),
    .out_max   (out_max),
    .blk_cnt   (blk_cnt),
    .ovr_cnt   (ovr_cnt),
    .zero_cnt  (zero_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: the pending block is just a list of accepted samples
  logic [DW-1:0] mq[$];
  logic          m_valid;
  logic [DW-1:0] m_mean, m_min, m_max;
  logic [CW-1:0] m_blk, m_ovr, m_zero;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] c);
    return (c == {CW{1'b1}}) ? c : c + 1'b1;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_valid = 1'b0;
    m_mean  = '0;
    m_min   = '0;
    m_max   = '0;
    m_blk   = '0;
    m_ovr   = '0;
    m_zero  = '0;
  endtask

  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    logic           was_valid;
    logic           done;
    longint unsigned s;
    logic [DW-1:0]  mn, mx;
    was_valid = m_valid;
    done      = 1'b0;
    if (clr) begin
      mq.delete();
      m_valid = 1'b0;
      m_blk   = '0;
      m_ovr   = '0;
      m_zero  = '0;
    end else begin
      if (v && d == 0) begin
        m_zero = sat(m_zero);
      end else if (v) begin
        mq.push_back(d);
        if (mq.size() == N) begin
          done = 1'b1;
          s  = 0;
          mn = mq[0];
          mx = mq[0];
          foreach (mq[i]) begin
            s += longint'(mq[i]);
            if (mq[i] < mn) mn = mq[i];
            if (mq[i] > mx) mx = mq[i];
          end
          mq.delete();
          if (!was_valid || rdy) begin
            m_valid = 1'b1;
            m_mean  = DW'(s / N);
            m_min   = mn;
            m_max   = mx;
            m_blk   = sat(m_blk);
          end else begin
            m_ovr = sat(m_ovr);
          end
        end
      end
      if (!done && was_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    check("out_valid", out_valid, m_valid);
    check("out_mean", out_mean, m_mean);
    check("out_min", out_min, m_min);
    check("out_max", out_max, m_max);
    check("blk_cnt", blk_cnt, m_blk);
    check("ovr_cnt", ovr_cnt, m_ovr);
    check("zero_cnt", zero_cnt, m_zero);
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    clear     = clr;
    @(posedge clk);
    model_step(v, d, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic check_zeroed(input string tag);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_mean"}, out_mean, '0);
    check({tag, "_min"}, out_min, '0);
    check({tag, "_max"}, out_max, '0);
    check({tag, "_blk"}, blk_cnt, '0);
    check({tag, "_ovr"}, ovr_cnt, '0);
    check({tag, "_zero"}, zero_cnt, '0);
  endtask

  initial begin
    logic [DW-1:0] d;
    int            r;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zeroed("reset");
    rst_n = 1'b1;

    // basic block
    step(1, 100, 0, 0); step(1, 200, 0, 0); step(1, 300, 0, 0); step(1, 400, 0, 0);
    check("t1_valid", out_valid, 1'b1);
    check("t1_mean", out_mean, 250);
    check("t1_min", out_min, 100);
    check("t1_max", out_max, 400);
    check("t1_blk", blk_cnt, 1);
    step(0, 0, 1, 0);

    // zero rejection interleaved
    step(1, 0, 0, 0); step(1, 10, 0, 0); step(1, 0, 0, 0);
    step(1, 20, 0, 0); step(1, 30, 0, 0); step(1, 40, 0, 0);
    check("t2_zero", zero_cnt, 2);
    check("t2_mean", out_mean, 25);
    check("t2_min", out_min, 10);
    check("t2_max", out_max, 40);
    step(0, 0, 1, 0);

    // two blocks without a consumer: second is an overrun
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0);
    check("t3_mean", out_mean, 2);
    check("t3_ovr", ovr_cnt, 1);
    check("t3_blk", blk_cnt, 3);

    // consume and load on the same edge
    step(1, 10, 0, 0); step(1, 20, 0, 0); step(1, 30, 0, 0); step(1, 40, 1, 0);
    check("t4_valid", out_valid, 1'b1);
    check("t4_mean", out_mean, 25);
    check("t4_ovr", ovr_cnt, 1);
    check("t4_blk", blk_cnt, 4);
    step(0, 0, 1, 0);

    // clear mid-block, same-cycle sample ignored
    step(1, 5, 0, 0); step(1, 9, 0, 0); step(1, 1000, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 7, 0, 0);
    check("t5_mean", out_mean, 7);
    check("t5_min", out_min, 7);
    check("t5_max", out_max, 7);
    check("t5_blk", blk_cnt, 1);

    // async reset mid-block while a result is pending
    step(1, 50, 0, 0); step(1, 60, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zeroed("t6_async");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 1, 0, 0); step(1, 2, 0, 0); step(1, 3, 0, 0); step(1, 4, 0, 0);
    check("t6_mean", out_mean, 2);
    check("t6_min", out_min, 1);
    check("t6_max", out_max, 4);
    step(0, 0, 1, 0);

    // full-scale samples must not overflow the sum
    for (int i = 0; i < 4; i++) step(1, 32'hFFFF_FFFF, 0, 0);
    check("t7_mean", out_mean, 32'hFFFF_FFFF);

    // randomized traffic, including counter saturation
    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0:       d = '0;
        1:       d = 32'hFFFF_FFFF;
        2, 3:    d = $urandom;
        default: d = DW'($urandom_range(1, 1000));
      endcase
      step(($urandom_range(0, 9) < 7), d, $urandom_range(0, 1) == 1, $urandom_range(0, 199) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
